// File: rtl/phase_corr_pkg.sv
// Shared constants, FSM state type and index-to-shift mapping for the
// phase-correlation peak finder.
package phase_corr_pkg;

  localparam int DIM  = 32;
  localparam int W    = 16;
  localparam int IDXW = $clog2(DIM);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT
  } state_t;

  // Indices in the upper half are negative shifts (i - DIM). With DIM a power
  // of two, that is just the index's MSB replicated as the new sign bit.
  function automatic logic signed [IDXW:0] idx_to_shift(input logic [IDXW-1:0] idx);
    return {idx[IDXW-1], idx};
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter over a DIM x DIM surface, column fastest.
// Clear wins over enable; last_pos flags position (DIM-1, DIM-1).
module raster_counter #(
  parameter int DIM = 32
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(DIM)-1:0]     row,
  output logic [$clog2(DIM)-1:0]     col,
  output logic                       last_pos
);

  localparam int IW = $clog2(DIM);

  always_ff @(posedge clk) begin
    if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      // Column wraps DIM-1 -> 0 on its own because DIM is a power of two.
      col <= col + IW'(1);
      if (col == IW'(DIM - 1)) begin
        row <= row + IW'(1);
      end
    end
  end

  assign last_pos = (row == IW'(DIM - 1)) && (col == IW'(DIM - 1));

endmodule

// File: rtl/phase_corr_peak_finder.sv
// Streaming argmax over one DIM x DIM correlation surface; emits the peak's
// signed (dx, dy) shift, value and a frame-length error flag per frame.
module phase_corr_peak_finder
  import phase_corr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [W-1:0]    s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [IDXW:0]   m_dx,
  output logic signed [IDXW:0]   m_dy,
  output logic signed [W-1:0]    m_peak,
  output logic                   m_err,
  output state_t                 state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid holds its payload stable until that edge.
  logic                 xfer;
  logic                 frame_end;
  logic                 upd;
  logic                 last_pos;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [IDXW-1:0]      row;
  logic [IDXW-1:0]      col;
  logic [IDXW-1:0]      best_row;
  logic [IDXW-1:0]      best_col;
  logic signed [W-1:0]  best;

  assign xfer      = s_valid && s_ready;
  assign frame_end = s_last || last_pos;
  // Strict compare keeps the earliest raster position on ties.
  assign upd       = (state == IDLE) || (s_data > best);
  assign cnt_clr   = rst || (xfer && frame_end);
  assign cnt_en    = xfer && !frame_end;

  raster_counter #(.DIM(DIM)) u_cnt (
    .clk      (clk),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .row      (row),
    .col      (col),
    .last_pos (last_pos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_dx     <= '0;
      m_dy     <= '0;
      m_peak   <= '0;
      m_err    <= 1'b0;
      best     <= '0;
      best_row <= '0;
      best_col <= '0;
    end else begin
      case (state)
        IDLE, SCAN: begin
          s_ready <= 1'b1;
          if (xfer) begin
            if (upd) begin
              best     <= s_data;
              best_row <= row;
              best_col <= col;
            end
            if (frame_end) begin
              // Result folds in the final sample directly rather than waiting
              // a cycle for the best registers to settle.
              state   <= RESULT;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_peak  <= upd ? s_data : best;
              m_dx    <= idx_to_shift(upd ? col : best_col);
              m_dy    <= idx_to_shift(upd ? row : best_row);
              m_err   <= (s_last != last_pos);
            end else begin
              state <= SCAN;
            end
          end
        end
        RESULT: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phase_corr_peak_finder.md
Name: phase_corr_peak_finder

Overview:
Streaming argmax stage for the phase-correlation chain. It sits downstream of the inverse 2D FFT that turns the normalised cross-power spectrum back into a correlation surface. It consumes one DIM x DIM real-valued surface in raster order, tracks the largest sample and its location, then emits one signed motion vector (dx, dy) per frame over a valid/ready handshake.

Parameters:
- DIM, 32: surface side length; power of two, >= 4.
- W, 16: sample width, signed two's complement (matches the FFT datapath word).
- IDXW, $clog2(DIM): row/column index width.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- s_valid, input, 1: input sample valid.
- s_ready, output, 1: block accepts a sample this cycle.
- s_data, input, W: signed real part of the correlation sample.
- s_last, input, 1: marks the final sample of a frame.
- m_valid, output, 1: result valid.
- m_ready, input, 1: downstream accepts the result.
- m_dx, output, IDXW+1: signed horizontal shift (column).
- m_dy, output, IDXW+1: signed vertical shift (row).
- m_peak, output, W: peak sample value.
- m_err, output, 1: frame-length mismatch flag.

Behaviour:
- Reset values: s_ready=0 in the reset cycle, then 1 from the following cycle. m_valid=0, m_dx=0, m_dy=0, m_peak=0, m_err=0. Counters and best registers are cleared; state=IDLE.
- Sample transfer occurs when s_valid && s_ready. Order is raster: column index fastest, row index slowest. Sample n maps to row=n/DIM, col=n%DIM.
- States:
  - IDLE: s_ready=1. The first transfer loads best=s_data and best position=(0,0), then moves to SCAN. If that first sample also carries s_last, go to RESULT with err=1.
  - SCAN: s_ready=1. On each transfer, if s_data > best (signed, strictly greater), update best and position. Ties keep the earlier raster position. Column counter wraps DIM-1 -> 0 and increments the row.
  - Frame end: end of frame is a transfer with s_last=1 or the transfer at count DIM*DIM-1, whichever comes first. Go to RESULT.
  - Error: err=1 if s_last and the final count disagree (early s_last, or count reaches DIM*DIM-1 without s_last). A late s_last therefore lands on the next frame's first sample and also flags that frame.
  - RESULT: s_ready=0 and m_valid=1. Outputs are registered and stable until m_valid && m_ready, then return to IDLE with counters cleared.
- Latency: m_valid rises on the cycle after the final sample transfer. The result is built from the best registers including that final sample.
- Shift mapping: index i < DIM/2 gives +i; i >= DIM/2 gives i-DIM. The result is sign-extended to IDXW+1 bits. Examples: col 31 -> dx=-1; col 16 -> dx=-16.
- Reset mid-frame or mid-RESULT discards all partial state and any pending result. No output is produced for that frame.
- Comparison uses full W-bit signed compare. There is no magnitude or abs; negative surfaces are legal.
- Throughput is one sample per cycle in SCAN, plus at least one bubble cycle per frame (the RESULT handshake).

Decomposition:
- Package phase_corr_pkg holds:
  - localparams DIM, W, IDXW;
  - state enum {IDLE, SCAN, RESULT};
  - function idx_to_shift(idx) returning the signed IDXW+1 shift.
- One natural sub-module: raster_counter (parameter DIM). It provides row/col counters, an enable input, a sync clear, and a last_pos flag. The FFT-side loaders can reuse it.

Test Plan:
- Single-peak frame: 1024 samples of 0 with 1000 at row 3, col 5, s_last on sample 1023 -> m_dx=5, m_dy=3, m_peak=1000, m_err=0, m_valid one cycle after the last transfer.
- Wrap-around frame: peak 2000 at row 30, col 17 -> m_dx=-15, m_dy=-2. A second frame with peak at row 16, col 0 -> m_dx=0, m_dy=-16.
- Ties and negatives:
  - All samples = -100 -> dx=0, dy=0, peak=-100.
  - Equal maxima 50 at raster 10 and 700 -> dx=10, dy=0.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid -> s_ready stays 0 and outputs stay frozen. Raise m_ready -> one handshake, then s_ready=1 on the next cycle and the following frame is processed correctly.
- Early s_last on sample 500 with peak at sample 200 -> result dx=8, dy=6, m_err=1. Missing s_last on sample 1023 -> frame closes at 1024 samples with m_err=1.
- Reset mid-frame after 300 samples, then a clean frame with peak at row 1, col 1 -> only one result: dx=1, dy=1, m_err=0.
